axil_csr_slave: RTL and testbench

- AXI4-Lite slave register file.
- Consumes the AXI-Lite master port produced by the PCIe BAR AXI-to-AXI-Lite conversion stage.
- Provides the control/status registers that host software reaches over the BAR: ID, scratch, control, status, a cycle counter and a write counter.
- Write and read channels run independently, each with a fully registered handshake.

---
 rtl/axil_csr_slave.sv | 115 +++++++++++
 tb/tb_axil_csr_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/axil_csr_slave.sv
// axil_csr_slave: AXI4-Lite control/status register file behind the PCIe BAR.
// Independent write (AW/W held, then commit) and read channels with registered responses.
module axil_csr_slave #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] ID_VALUE = 32'hACE0_0215,
  parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic [2:0]        s_axil_awprot,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic [2:0]        s_axil_arprot,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic [31:0]       ctrl_out,
  input  logic [31:0]       status_in
);
  localparam logic [0:0] W_IDLE = 1'b0, W_RESP = 1'b1, R_IDLE = 1'b0, R_DATA = 1'b1;
  logic [0:0] w_state, r_state;
  logic aw_held, w_held, commit, unused;
  logic [2:0] aw_idx, ar_idx;
  logic [3:0] w_strb;
  logic [1:0] wr_resp, rd_resp;
  logic [31:0] w_data, scratch, ctrl, cycle, wrcnt, cur, merged, rd_val;
  assign s_axil_bvalid = w_state == W_RESP;
  assign s_axil_rvalid = r_state == R_DATA;
  // Readies are forced low while reset is asserted and rise as soon as it releases.
  assign s_axil_awready = aresetn && !aw_held && !s_axil_bvalid;
  assign s_axil_wready = aresetn && !w_held && !s_axil_bvalid;
  assign s_axil_arready = aresetn && !s_axil_rvalid;
  assign ctrl_out = ctrl;
  assign commit = w_state == W_IDLE && aw_held && w_held;
  assign ar_idx = s_axil_araddr[4:2];
  assign unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};
  always_comb begin
    wr_resp = (aw_idx == 3'd1 || aw_idx == 3'd2) ? 2'b00 : (aw_idx[2] && aw_idx[1]) ? 2'b11 : 2'b10;
    rd_resp = (ar_idx[2] && ar_idx[1]) ? 2'b11 : 2'b00;
    cur = aw_idx == 3'd1 ? scratch : ctrl;
    merged = cur;
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = w_strb[i] ? w_data[8*i +: 8] : cur[8*i +: 8];
    case (ar_idx)
      3'd0:    rd_val = ID_VALUE;
      3'd1:    rd_val = scratch;
      3'd2:    rd_val = ctrl;
      3'd3:    rd_val = status_in;
      3'd4:    rd_val = cycle;
      3'd5:    rd_val = wrcnt;
      default: rd_val = '0;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      s_axil_bresp <= 2'b00;
      scratch <= '0;
      ctrl <= CTRL_RST;
      wrcnt <= '0;
    end else begin
      if (s_axil_awvalid && s_axil_awready) begin
        aw_held <= 1'b1;
        aw_idx <= s_axil_awaddr[4:2];
      end
      if (s_axil_wvalid && s_axil_wready) begin
        w_held <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held <= 1'b0;
        w_state <= W_RESP;
        s_axil_bresp <= wr_resp;
        if (wr_resp == 2'b00) begin
          wrcnt <= wrcnt + 32'd1;
          if (aw_idx == 3'd1) scratch <= merged;
          else ctrl <= merged;
        end
      end else if (s_axil_bvalid && s_axil_bready) w_state <= W_IDLE;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      s_axil_rdata <= '0;
      s_axil_rresp <= 2'b00;
    end else if (s_axil_arvalid && s_axil_arready) begin
      r_state <= R_DATA;
      s_axil_rdata <= rd_val;
      s_axil_rresp <= rd_resp;
    end else if (s_axil_rvalid && s_axil_rready) r_state <= R_IDLE;
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cycle <= '0;
    else cycle <= cycle + 32'd1;
  end
endmodule

// File: tb/tb_axil_csr_slave.sv
// tb_axil_csr_slave: directed + random AXI-Lite traffic checked against a register-map model.
module tb_axil_csr_slave;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [31:0] s_axil_awaddr = '0, s_axil_wdata = '0, s_axil_araddr = '0, status_in = '0;
  logic [2:0] s_axil_awprot = '0, s_axil_arprot = '0;
  logic [3:0] s_axil_wstrb = '0;
  logic s_axil_awvalid = 0, s_axil_wvalid = 0, s_axil_bready = 0, s_axil_arvalid = 0, s_axil_rready = 0;
  logic s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0] s_axil_bresp, s_axil_rresp;
  logic [31:0] s_axil_rdata, ctrl_out;
  int checks = 0, fails = 0;
  logic [31:0] scratch_m = '0, ctrl_m = '0, wrcnt_m = '0;
  axil_csr_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready), .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr),
    .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
    .s_axil_rready(s_axil_rready), .ctrl_out(ctrl_out), .status_in(status_in)
  );
  always #5 aclk = ~aclk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] exp_bresp(input logic [2:0] idx);
    return (idx == 3'd1 || idx == 3'd2) ? 2'b00 : (idx >= 3'd6) ? 2'b11 : 2'b10;
  endfunction
  function automatic logic [31:0] exp_rdata(input logic [2:0] idx, input logic [31:0] st);
    case (idx)
      3'd0: return 32'hACE0_0215;
      3'd1: return scratch_m;
      3'd2: return ctrl_m;
      3'd3: return st;
      3'd5: return wrcnt_m;
      default: return 32'h0;
    endcase
  endfunction
  // Starts and ends on a falling edge; W is offered `lead` cycles before AW.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, input int bhold, output logic [1:0] resp);
    bit aw_ok = 0, w_ok = 0;
    int n = 0;
    s_axil_awaddr = addr;
    s_axil_wdata = data;
    s_axil_wstrb = strb;
    while (!(aw_ok && w_ok) && n < 40) begin
      s_axil_wvalid = !w_ok;
      s_axil_awvalid = !aw_ok && n >= lead;
      #1;
      if (s_axil_awvalid && s_axil_awready) aw_ok = 1;
      if (s_axil_wvalid && s_axil_wready) w_ok = 1;
      @(negedge aclk);
      n++;
    end
    s_axil_awvalid = 0;
    s_axil_wvalid = 0;
    check("aw_w_handshake", {31'd0, aw_ok && w_ok}, 32'd1);
    n = 0;
    while (!s_axil_bvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    check("b_latency", n, 1);
    repeat (bhold) begin
      check("bvalid_hold", {31'd0, s_axil_bvalid}, 32'd1);
      check("ready_low", {30'd0, s_axil_awready, s_axil_wready}, 32'd0);
      check("ctrl_out_hold", ctrl_out, ctrl_m);
      @(negedge aclk);
    end
    resp = s_axil_bresp;
    s_axil_bready = 1;
    @(negedge aclk);
    s_axil_bready = 0;
    check("bvalid_drop", {31'd0, s_axil_bvalid}, 32'd0);
  endtask
  task automatic axi_read(input logic [31:0] addr, input int hold, output logic [31:0] data,
                          output logic [1:0] resp);
    int n = 0;
    s_axil_araddr = addr;
    s_axil_arvalid = 1;
    #1;
    while (!s_axil_arready && n < 20) begin
      @(negedge aclk);
      #1;
      n++;
    end
    check("ar_ready", {31'd0, s_axil_arready}, 32'd1);
    @(negedge aclk);
    s_axil_arvalid = 0;
    status_in = $urandom;
    check("r_latency", {31'd0, s_axil_rvalid}, 32'd1);
    data = s_axil_rdata;
    resp = s_axil_rresp;
    repeat (hold) begin
      @(negedge aclk);
      check("rdata_stable", s_axil_rdata, data);
      check("rvalid_stable", {30'd0, s_axil_rvalid, s_axil_rresp == resp}, 32'd3);
    end
    s_axil_rready = 1;
    @(negedge aclk);
    s_axil_rready = 0;
    check("rvalid_drop", {31'd0, s_axil_rvalid}, 32'd0);
  endtask
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int lead, input int bhold);
    logic [2:0] idx;
    logic [1:0] er, resp;
    logic [31:0] cur;
    idx = addr[4:2];
    er = exp_bresp(idx);
    if (er == 2'b00) begin
      cur = idx == 3'd1 ? scratch_m : ctrl_m;
      for (int b = 0; b < 4; b++) if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
      if (idx == 3'd1) scratch_m = cur;
      else ctrl_m = cur;
      wrcnt_m = wrcnt_m + 1;
    end
    axi_write(addr, data, strb, lead, bhold, resp);
    check("bresp", resp, er);
    check("ctrl_out", ctrl_out, ctrl_m);
  endtask
  task automatic do_read(input logic [31:0] addr, input int hold, output logic [31:0] data);
    logic [2:0] idx;
    logic [31:0] st;
    logic [1:0] resp;
    idx = addr[4:2];
    st = $urandom;
    status_in = st;
    axi_read(addr, hold, data, resp);
    check("rresp", resp, idx >= 3'd6 ? 2'b11 : 2'b00);
    if (idx != 3'd4) check("rdata", data, exp_rdata(idx, st));
  endtask
  initial begin
    logic [31:0] d, c1, c2;
    repeat (3) @(negedge aclk);
    check("rst_readies", {29'd0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'd0);
    check("rst_valids", {30'd0, s_axil_bvalid, s_axil_rvalid}, 32'd0);
    check("rst_rdata", s_axil_rdata, 32'd0);
    check("rst_ctrl", ctrl_out, 32'd0);
    aresetn = 1;
    #1;
    check("rel_readies", {29'd0, s_axil_awready, s_axil_wready, s_axil_arready}, 32'd7);
    @(negedge aclk);
    do_read(32'h00, 0, d);
    check("id", d, 32'hACE0_0215);
    do_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_write(32'h04, 32'h0000_0011, 4'b0001, 0, 0);
    do_read(32'h04, 0, d);
    check("scratch_merge", d, 32'hDEAD_BE11);
    do_read(32'h14, 0, d);
    check("wrcnt_two", d, 32'd2);
    do_write(32'h08, 32'h5, 4'hF, 2, 4);
    check("ctrl_five", ctrl_out, 32'h5);
    do_write(32'h00, 32'h1234_5678, 4'hF, 0, 0);
    do_read(32'h00, 0, d);
    check("id_unchanged", d, 32'hACE0_0215);
    do_read(32'h14, 0, d);
    check("wrcnt_slverr", d, 32'd3);
    do_write(32'h18, 32'hFFFF_FFFF, 4'hF, 1, 0);
    do_read(32'h1C, 0, d);
    check("unmapped_rdata", d, 32'd0);
    do_read(32'h10, 0, c1);
    repeat (3) @(negedge aclk);
    do_read(32'h10, 3, c2);
    check("cycle_delta", c2 - c1, 32'd5);
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom_range(0, 31), $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2));
      else
        do_read($urandom_range(0, 31), $urandom_range(0, 2), d);
    end
    do_write(32'h08, 32'h5, 4'hF, 0, 0);
    s_axil_awaddr = 32'h04;
    s_axil_wdata = 32'hCAFE_F00D;
    s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1;
    s_axil_wvalid = 1;
    @(negedge aclk);
    s_axil_awvalid = 0;
    s_axil_wvalid = 0;
    @(negedge aclk);
    check("pre_rst_bvalid", {31'd0, s_axil_bvalid}, 32'd1);
    check("pre_rst_ctrl", ctrl_out, 32'h5);
    #2 aresetn = 0;
    #1;
    check("async_bvalid", {31'd0, s_axil_bvalid}, 32'd0);
    check("async_ctrl", ctrl_out, 32'd0);
    @(negedge aclk);
    aresetn = 1;
    scratch_m = '0;
    ctrl_m = '0;
    wrcnt_m = '0;
    repeat (2) @(negedge aclk);
    check("no_stale_b", {31'd0, s_axil_bvalid}, 32'd0);
    do_read(32'h04, 0, d);
    check("scratch_rst", d, 32'd0);
    do_read(32'h14, 0, d);
    check("wrcnt_rst", d, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
